uart_rx: RTL and testbench

Receive half of the UART link. Recovers 8-bit frames from the serial line: start bit, 8 data bits LSB first, optional parity, one stop bit. Uses an oversampling clock with a configurable prescale. Delivers each good byte with a one-cycle `data_valid` pulse and reports parity and stop-bit errors. Sits between the RX pad (after the board-level buffer) and the system register/FIFO layer, mirroring the existing transmit path.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: oversampled start/data/parity/stop recovery with majority-vote sampling
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                  rx_meta_q, rx_s_q;
    logic [2:0]            state_q, state_d;
    logic [PRESC_W-1:0]    edge_q, edge_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [PRESC_W-1:0]    half;
    logic [PRESC_W-1:0]    last;
    logic                  edge_last;
    logic                  at_res;
    logic                  maj;

    always_comb begin
        half      = presc_q >> 1;
        last      = presc_q - PRESC_W'(1);
        edge_last = (edge_q == last);
        at_res    = (edge_q == half + PRESC_W'(2));
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_last ? '0 : edge_q + PRESC_W'(1);
        bit_d     = bit_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        armed_d   = armed_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        // Three samples straddling mid-bit feed the majority vote
        if (edge_q == half - PRESC_W'(1)) samp_d[0] = rx_s_q;
        if (edge_q == half)               samp_d[1] = rx_s_q;
        if (edge_q == half + PRESC_W'(1)) samp_d[2] = rx_s_q;

        case (state_q)
            S_IDLE: begin
                edge_d    = '0;
                bit_d     = '0;
                par_bad_d = 1'b0;
                if (rx_s_q) armed_d = 1'b1;
                // A line stuck low after a framing error must go high before a new start counts
                if (!rx_s_q && armed_q) begin
                    state_d   = S_START;
                    edge_d    = PRESC_W'(1);
                    presc_d   = prescale;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    armed_d   = 1'b0;
                end
            end
            S_START: begin
                if (at_res && maj) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (edge_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_res) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (edge_last) begin
                    bit_d = bit_q + BCW'(1);
                    if (bit_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (edge_last) begin
                    if (maj != ((^shift_q) ^ par_typ_q)) begin
                        pe_d      = 1'b1;
                        par_bad_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_s_q) armed_d = 1'b1;
                if (edge_last) begin
                    if (!maj) begin
                        se_d = 1'b1;
                    end else if (!par_bad_q) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            samp_q    <= 3'b111;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            armed_q   <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            armed_q   <= armed_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frames for uart_rx against a frame-level reference model
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk(clk), .rstn(rstn), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];
    int         pe_q[$];
    int         se_q[$];

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(P_DATA);
        end
        if (par_err) pe_q.push_back(cyc);
        if (stp_err) se_q.push_back(cyc);
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_pdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Drives one frame on the nominal bit grid; k is the cycle RX_IN falls
    task automatic send_frame(input int p, input logic pen, input logic ptyp, input logic [7:0] d,
                              input logic bad_par, input logic bad_stop, input logic jit,
                              input logic scr, output int k);
        logic [10:0] lvl;
        int          j[11];
        int          f, gb, b, off;
        logic        lv;
        f = pen ? 11 : 10;
        lvl = '1;
        lvl[0] = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i+1] = d[i];
        if (pen) lvl[9] = ($countones(d) % 2 == 1) ^ ptyp ^ bad_par;
        lvl[f-1] = !bad_stop;
        for (int i = 0; i < 11; i++) j[i] = (jit && i >= 1) ? int'($urandom_range(0, 2)) - 1 : 0;
        gb = jit ? int'($urandom_range(0, f - 1)) : -1;
        prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        k = cyc;
        for (int c = 0; c < f * p; c++) begin
            b   = c / p;
            off = c % p;
            lv  = lvl[b];
            if (b + 1 < f && off == p - 1 && j[b+1] == -1) lv = lvl[b+1];
            else if (b >= 1 && off == 0 && j[b] == 1) lv = lvl[b-1];
            if (b == gb && off == p / 2) lv = !lv;
            RX_IN = lv;
            if (scr && c == p) begin
                prescale = 6'(pick_p());
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
            end
            tick();
        end
        RX_IN = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input int k, input int p, input logic pen,
                                input logic [7:0] d, input logic bad_par, input logic bad_stop,
                                input logic chk_time);
        int   t_end;
        logic e_pe, e_se, e_dv;
        t_end = k + 2 + (pen ? 11 : 10) * p;
        e_pe  = pen & bad_par;
        e_se  = bad_stop;
        e_dv  = !e_pe && !e_se;
        if (e_dv) begin
            chk({tag, " dv present"}, dv_cyc_q.size() > 0, 1);
            if (dv_cyc_q.size() > 0) begin
                if (chk_time) chk({tag, " dv cycle"}, dv_cyc_q.pop_front(), t_end);
                else void'(dv_cyc_q.pop_front());
                chk({tag, " dv data"}, dv_dat_q.pop_front(), d);
            end
            model_pdata = d;
        end
        if (e_pe) begin
            chk({tag, " par_err present"}, pe_q.size() > 0, 1);
            if (pe_q.size() > 0) chk({tag, " par_err cycle"}, pe_q.pop_front(), k + 2 + 10 * p);
        end
        if (e_se) begin
            chk({tag, " stp_err present"}, se_q.size() > 0, 1);
            if (se_q.size() > 0) chk({tag, " stp_err cycle"}, se_q.pop_front(), t_end);
        end
    endtask

    task automatic expect_quiet(input string tag);
        chk({tag, " stray dv"}, dv_cyc_q.size(), 0);
        chk({tag, " stray par_err"}, pe_q.size(), 0);
        chk({tag, " stray stp_err"}, se_q.size(), 0);
        chk({tag, " P_DATA"}, P_DATA, model_pdata);
        dv_cyc_q.delete();
        dv_dat_q.delete();
        pe_q.delete();
        se_q.delete();
    endtask

    initial begin
        int         k, k0, k1, k2, p;
        logic       pen, ptyp, bp, bs;
        logic [7:0] d, d0, d1, d2, dd;

        repeat (3) tick();
        chk("reset P_DATA", P_DATA, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset par_err", par_err, 0);
        chk("reset stp_err", stp_err, 0);
        rstn = 1'b1;
        repeat (3) tick();

        send_frame(8, 0, 0, 8'hA5, 0, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("p8 A5", k, 8, 0, 8'hA5, 0, 0, 1);
        expect_quiet("p8 A5");

        send_frame(16, 1, 0, 8'h3C, 0, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("p16 even 3C", k, 16, 1, 8'h3C, 0, 0, 1);
        expect_quiet("p16 even 3C");
        send_frame(16, 1, 0, 8'h3C, 1, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("p16 bad parity", k, 16, 1, 8'h3C, 1, 0, 1);
        expect_quiet("p16 bad parity");

        send_frame(32, 0, 0, 8'h81, 0, 1, 0, 0, k);
        repeat (4) tick();
        expect_frame("p32 stop err", k, 32, 0, 8'h81, 0, 1, 1);
        expect_quiet("p32 stop err");
        send_frame(32, 0, 0, 8'h55, 0, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("p32 55", k, 32, 0, 8'h55, 0, 0, 1);
        expect_quiet("p32 55");

        prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (4) tick();
        RX_IN = 1'b1;
        repeat (10) tick();
        expect_quiet("false start");
        send_frame(16, 0, 0, 8'h96, 0, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("after false start", k, 16, 0, 8'h96, 0, 0, 1);
        expect_quiet("after false start");

        send_frame(8, 1, 1, 8'h00, 0, 0, 0, 0, k0);
        send_frame(8, 1, 1, 8'hFF, 0, 0, 0, 0, k1);
        send_frame(8, 1, 1, 8'h5A, 0, 0, 0, 0, k2);
        repeat (4) tick();
        expect_frame("b2b 00", k0, 8, 1, 8'h00, 0, 0, 1);
        expect_frame("b2b FF", k1, 8, 1, 8'hFF, 0, 0, 1);
        expect_frame("b2b 5A", k2, 8, 1, 8'h5A, 0, 0, 1);
        expect_quiet("b2b");

        for (int r = 0; r < 4; r++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            send_frame(8, 1, 1, d0, 0, 0, 1, 0, k0);
            send_frame(8, 1, 1, d1, 0, 0, 1, 0, k1);
            send_frame(8, 1, 1, d2, 0, 0, 1, 0, k2);
            repeat (4) tick();
            expect_frame("jitter f0", k0, 8, 1, d0, 0, 0, 1);
            expect_frame("jitter f1", k1, 8, 1, d1, 0, 0, 1);
            expect_frame("jitter f2", k2, 8, 1, d2, 0, 0, 1);
            expect_quiet("jitter");
        end

        for (int r = 0; r < 12; r++) begin
            p    = pick_p();
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            d    = 8'($urandom);
            bp   = pen && ($urandom_range(0, 3) == 0);
            bs   = ($urandom_range(0, 4) == 0);
            send_frame(p, pen, ptyp, d, bp, bs, 0, 1, k);
            repeat (4) tick();
            expect_frame("random", k, p, pen, d, bp, bs, 1);
            expect_quiet("random");
        end

        send_frame(8, 0, 0, 8'h7E, 0, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("pre-reset 7E", k, 8, 0, 8'h7E, 0, 0, 1);
        expect_quiet("pre-reset 7E");

        dd       = 8'h3A;
        prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 4; i++) begin
            RX_IN = dd[i];
            repeat (16) tick();
        end
        RX_IN = dd[4];
        repeat (8) tick();
        rstn = 1'b0;
        #1;
        chk("mid-frame reset P_DATA", P_DATA, 0);
        chk("mid-frame reset data_valid", data_valid, 0);
        chk("mid-frame reset par_err", par_err, 0);
        chk("mid-frame reset stp_err", stp_err, 0);
        model_pdata = 8'h00;
        RX_IN = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (3) tick();
        send_frame(16, 0, 0, 8'hC3, 0, 0, 0, 0, k);
        repeat (4) tick();
        expect_frame("post-reset C3", k, 16, 0, 8'hC3, 0, 0, 1);
        expect_quiet("post-reset C3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
